led_refresh_scheduler: RTL

- Shares the LED cell buffer between NUM_CLIENTS producers using round-robin write grants.
- Sequences LED-controller frames: drives `refresh_lock` while any client owns the buffer, and issues single-cycle `refresh` pulses only when data is dirty and the minimum frame period has elapsed.
- Keeps the strip alive with periodic forced refreshes.
- Sits between the cell-producing logic (register/display cell updaters) and the LED controller's `refresh`/`refresh_lock` inputs.

---
 rtl/led_refresh_scheduler.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/led_refresh_scheduler.sv
// LED cell buffer arbiter and frame sequencer: round-robin write grants,
// refresh_lock while a client owns the buffer, rate-limited refresh pulses
// and periodic keepalive frames.
module led_refresh_scheduler #(
    parameter int unsigned NUM_CLIENTS      = 3,
    parameter int unsigned MIN_FRAME_CYCLES = 1500000,
    parameter int unsigned KEEPALIVE_CYCLES = 50000000,
    parameter int unsigned MAX_HOLD_CYCLES  = 65536
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic [NUM_CLIENTS-1:0] done,
    output logic [NUM_CLIENTS-1:0] gnt,
    output logic                   refresh_lock,
    output logic                   refresh,
    output logic [NUM_CLIENTS-1:0] timeout_err
);

    localparam int unsigned HOLDOFF_W = $clog2(MIN_FRAME_CYCLES);
    localparam int unsigned KEEP_W    = $clog2(KEEPALIVE_CYCLES);
    localparam int unsigned HOLD_W    = $clog2(MAX_HOLD_CYCLES);
    localparam int unsigned RR_W      = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    localparam logic [HOLDOFF_W-1:0] HOLDOFF_RELOAD = HOLDOFF_W'(MIN_FRAME_CYCLES - 1);
    localparam logic [KEEP_W-1:0]    KEEP_RELOAD    = KEEP_W'(KEEPALIVE_CYCLES - 1);
    localparam logic [HOLD_W-1:0]    HOLD_LAST      = HOLD_W'(MAX_HOLD_CYCLES - 1);
    localparam logic [RR_W-1:0]      RR_RESET       = RR_W'(NUM_CLIENTS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GUARD,
        S_GRANT
    } state_t;

    state_t                   state_q, state_d;
    logic [NUM_CLIENTS-1:0]   gnt_d, timeout_err_d;
    logic                     refresh_lock_d, refresh_d;
    logic                     dirty_q, dirty_d;
    logic [HOLDOFF_W-1:0]     holdoff_q, holdoff_d;
    logic [KEEP_W-1:0]        keepalive_q, keepalive_d;
    logic [HOLD_W-1:0]        hold_cnt_q, hold_cnt_d;
    logic [RR_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic                     guard_q, guard_d;

    logic [RR_W-1:0]          pick;
    logic                     pick_valid;
    logic                     ka_zero;

    assign ka_zero = (keepalive_q == '0);

    // Round-robin pick: first requester after the last granted index.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        for (int unsigned i = 1; i <= NUM_CLIENTS; i++) begin
            if (!pick_valid && req[RR_W'((32'(rr_ptr_q) + i) % NUM_CLIENTS)]) begin
                pick       = RR_W'((32'(rr_ptr_q) + i) % NUM_CLIENTS);
                pick_valid = 1'b1;
            end
        end
    end

    // Next-state, counters and registered-output next values.
    always_comb begin
        state_d        = state_q;
        gnt_d          = gnt;
        refresh_lock_d = refresh_lock;
        refresh_d      = 1'b0;
        timeout_err_d  = timeout_err;
        dirty_d        = dirty_q | ka_zero;
        holdoff_d      = (holdoff_q == '0) ? holdoff_q : holdoff_q - HOLDOFF_W'(1);
        keepalive_d    = ka_zero ? KEEP_RELOAD : keepalive_q - KEEP_W'(1);
        hold_cnt_d     = hold_cnt_q;
        rr_ptr_d       = rr_ptr_q;
        guard_d        = guard_q;

        case (state_q)
            S_IDLE: begin
                // A keepalive expiry counts as dirty in the same cycle.
                if ((dirty_q || ka_zero) && (holdoff_q == '0)) begin
                    refresh_d   = 1'b1;
                    dirty_d     = 1'b0;
                    holdoff_d   = HOLDOFF_RELOAD;
                    keepalive_d = KEEP_RELOAD;
                    guard_d     = 1'b0;
                    state_d     = S_GUARD;
                end else if (pick_valid) begin
                    gnt_d          = '0;
                    gnt_d[pick]    = 1'b1;
                    refresh_lock_d = 1'b1;
                    rr_ptr_d       = pick;
                    hold_cnt_d     = '0;
                    state_d        = S_GRANT;
                end
            end
            S_GUARD: begin
                // Two cycles with lock low so the controller snapshots cells.
                if (guard_q) begin
                    guard_d = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    guard_d = 1'b1;
                end
            end
            S_GRANT: begin
                hold_cnt_d = (hold_cnt_q == HOLD_LAST) ? hold_cnt_q : hold_cnt_q + HOLD_W'(1);
                if (done[rr_ptr_q]) begin
                    dirty_d        = 1'b1;
                    gnt_d          = '0;
                    refresh_lock_d = 1'b0;
                    state_d        = S_IDLE;
                end else if (!req[rr_ptr_q]) begin
                    gnt_d          = '0;
                    refresh_lock_d = 1'b0;
                    state_d        = S_IDLE;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    timeout_err_d[rr_ptr_q] = 1'b1;
                    dirty_d                 = 1'b1;
                    gnt_d                   = '0;
                    refresh_lock_d          = 1'b0;
                    state_d                 = S_IDLE;
                end
            end
            default: begin
                gnt_d          = '0;
                refresh_lock_d = 1'b0;
                state_d        = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            gnt          <= '0;
            refresh_lock <= 1'b0;
            refresh      <= 1'b0;
            timeout_err  <= '0;
            dirty_q      <= 1'b1;
            holdoff_q    <= '0;
            keepalive_q  <= KEEP_RELOAD;
            hold_cnt_q   <= '0;
            rr_ptr_q     <= RR_RESET;
            guard_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt          <= gnt_d;
            refresh_lock <= refresh_lock_d;
            refresh      <= refresh_d;
            timeout_err  <= timeout_err_d;
            dirty_q      <= dirty_d;
            holdoff_q    <= holdoff_d;
            keepalive_q  <= keepalive_d;
            hold_cnt_q   <= hold_cnt_d;
            rr_ptr_q     <= rr_ptr_d;
            guard_q      <= guard_d;
        end
    end

endmodule
